// File: rtl/adc_blk_pkg.sv
// Shared definitions for the ADC block builder: mode encodings, FSM state
// type and parameter defaults.
// Purely declarative. It has no latency or backpressure of its own.
package adc_blk_pkg;

    localparam int AD_W_DEF  = 8;
    localparam int BLK_W_DEF = 128;
    localparam int DIV_DEF   = 8;

    typedef enum logic {
        MODE_REPLICATE = 1'b0,
        MODE_PACK      = 1'b1
    } mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/adc_sample_timer.sv
// Sample-period divider: generates the ADC conversion strobe and the capture strobe.
// o_adc_en_n is registered and precedes the capture edge by one cycle. o_cap is combinational.
// No backpressure. All counting freezes while i_locked is low.
//
// Ports: i_clk/i_rst clock and async reset, i_locked clock-source lock,
//        i_run FSM in RUN, o_adc_en_n conversion strobe, o_cap capture enable.
module adc_sample_timer
#(
    parameter int DIV = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_locked,
    input  logic i_run,
    output logic o_adc_en_n,
    output logic o_cap
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_PRE = CW'(DIV - 2);

    logic [CW-1:0] r_cnt;
    logic          r_en;

    // The divider runs in IDLE too, so the sample phase is set by reset release rather than by start.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_en  <= 1'b0;
        end else begin
            if (i_locked) begin
                r_cnt <= (r_cnt == CNT_MAX) ? '0 : r_cnt + 1'b1;
            end
            // Gate with lock so a frozen count cannot repeat the strobe.
            r_en <= i_run & i_locked & (r_cnt == CNT_PRE);
        end
    end

    assign o_adc_en_n = r_en;
    assign o_cap      = i_run & i_locked & (r_cnt == CNT_MAX);

endmodule

// File: rtl/adc_block_builder.sv
// Assembles ADC samples into wide blocks. Each bit of a sample is replicated across one field (REPLICATE), or NS samples are packed side by side (PACK).
// blk_valid rises one cycle after the capture edge that completes a block.
// blk_valid/blk_ready handshake. A completed block that meets a stalled output is dropped and the sticky overrun flag is set.
//
// Ports: ADC_CLK_90 clock, rst async reset, locked lock input, start arm,
//        mode REPLICATE/PACK, thresh LED threshold, ad_data ADC bus,
//        ADC_EN_N conversion strobe, blk_data/blk_valid/blk_ready output
//        block stream, led_open sample>thresh, overrun sticky drop flag.
module adc_block_builder
    import adc_blk_pkg::*;
#(
    parameter int AD_W  = AD_W_DEF,
    parameter int BLK_W = BLK_W_DEF,   // must be a multiple of AD_W
    parameter int DIV   = DIV_DEF
) (
    input  logic             ADC_CLK_90,
    input  logic             rst,
    input  logic             locked,
    input  logic             start,
    input  logic             mode,
    input  logic [AD_W-1:0]  thresh,
    input  logic [AD_W-1:0]  ad_data,
    output logic             ADC_EN_N,
    output logic [BLK_W-1:0] blk_data,
    output logic             blk_valid,
    input  logic             blk_ready,
    output logic             led_open,
    output logic             overrun
);

    localparam int NS = BLK_W / AD_W;
    localparam int SW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [SW-1:0] SLOT_MAX = SW'(NS - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_run;
    logic             w_cap;
    logic             r_cap_d;
    logic [AD_W-1:0]  r_ad_q;
    mode_t            r_mode;
    logic [SW-1:0]    r_slot;
    logic [BLK_W-1:0] r_shadow;
    logic [BLK_W-1:0] r_blk_data;
    logic             r_blk_valid;
    logic             r_led;
    logic             r_overrun;
    logic [BLK_W-1:0] w_rep_blk;
    logic [BLK_W-1:0] w_pack_blk;
    logic [BLK_W-1:0] w_new_blk;
    logic             w_done;

    always_ff @(posedge ADC_CLK_90 or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // RUN is terminal. Only reset returns the block to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_IDLE && start && locked) w_state_nxt = ST_RUN;
    end

    assign w_run = (r_state == ST_RUN);

    adc_sample_timer #(.DIV(DIV)) u_timer (
        .i_clk      (ADC_CLK_90),
        .i_rst      (rst),
        .i_locked   (locked),
        .i_run      (w_run),
        .o_adc_en_n (ADC_EN_N),
        .o_cap      (w_cap)
    );

    always_comb begin
        w_rep_blk = '0;
        for (int i = 0; i < AD_W; i++) begin
            w_rep_blk[i*NS +: NS] = {NS{r_ad_q[i]}};
        end
    end

    // Shadow with the current sample merged in. The final slot's sample reaches blk_data without an extra cycle.
    always_comb begin
        w_pack_blk = r_shadow;
        w_pack_blk[int'(r_slot)*AD_W +: AD_W] = r_ad_q;
    end

    assign w_new_blk = (r_mode == MODE_PACK) ? w_pack_blk : w_rep_blk;
    assign w_done    = r_cap_d & ((r_mode == MODE_REPLICATE) | (r_slot == SLOT_MAX));

    // A sample is taken on the capture edge and consumed on the following edge (r_cap_d).
    always_ff @(posedge ADC_CLK_90 or posedge rst) begin
        if (rst) begin
            r_cap_d     <= 1'b0;
            r_ad_q      <= '0;
            r_mode      <= MODE_REPLICATE;
            r_slot      <= '0;
            r_shadow    <= '0;
            r_blk_data  <= '0;
            r_blk_valid <= 1'b0;
            r_led       <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_cap_d <= w_cap;
            if (w_cap) begin
                r_ad_q <= ad_data;
                // Mode is sampled only at a block boundary. A mid-block change waits for the next block.
                if (r_slot == '0) r_mode <= mode_t'(mode);
            end
            if (r_cap_d) begin
                r_led <= (r_ad_q > thresh);
                if (r_mode == MODE_PACK) begin
                    r_shadow <= w_pack_blk;
                    r_slot   <= (r_slot == SLOT_MAX) ? '0 : r_slot + 1'b1;
                end
            end
            if (w_done) begin
                if (!r_blk_valid || blk_ready) begin
                    r_blk_data  <= w_new_blk;
                    r_blk_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_blk_valid && blk_ready) begin
                r_blk_valid <= 1'b0;
            end
        end
    end

    assign blk_data  = r_blk_data;
    assign blk_valid = r_blk_valid;
    assign led_open  = r_led;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_adc_block_builder.sv
// Testbench for adc_block_builder. A cycle-level reference model built from the block's rules predicts the outputs.
// Expected blocks are queued as they are predicted, and a negedge monitor pops them on each transfer.
// Directed scenarios run first, followed by a randomized soak.
module tb_adc_block_builder;
    import adc_blk_pkg::*;

    localparam int AD_W  = 8;
    localparam int BLK_W = 128;
    localparam int DIV   = 8;
    localparam int NS    = BLK_W / AD_W;

    localparam logic [BLK_W-1:0] REP_A5   = 128'hFFFF_0000_FFFF_0000_0000_FFFF_0000_FFFF;
    localparam logic [BLK_W-1:0] PACK_SEQ = 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100;
    localparam logic [BLK_W-1:0] PACK_40  = 128'h4F4E_4D4C_4B4A_4948_4746_4544_4342_4140;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             locked    = 1'b1;
    logic             start     = 1'b0;
    logic             mode      = 1'b0;
    logic             blk_ready = 1'b1;
    logic [AD_W-1:0]  thresh    = 8'h0F;
    logic [AD_W-1:0]  ad_data   = '0;
    logic             adc_en_n;
    logic             blk_valid;
    logic             led_open;
    logic             overrun;
    logic [BLK_W-1:0] blk_data;

    always #5 clk = ~clk;

    adc_block_builder #(.AD_W(AD_W), .BLK_W(BLK_W), .DIV(DIV)) dut (
        .ADC_CLK_90 (clk),
        .rst        (rst),
        .locked     (locked),
        .start      (start),
        .mode       (mode),
        .thresh     (thresh),
        .ad_data    (ad_data),
        .ADC_EN_N   (adc_en_n),
        .blk_data   (blk_data),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .led_open   (led_open),
        .overrun    (overrun)
    );

    int m_chk = 0, m_pass = 0;   // monitor comparisons
    int d_chk = 0, d_pass = 0;   // directed comparisons

    // Reference model state
    int              m_cnt  = 0;
    bit              m_run  = 0, m_en = 0, m_pend = 0, m_mode = 0;
    bit              m_valid = 0, m_over = 0, m_led = 0;
    logic [AD_W-1:0] m_s    = '0;
    logic [AD_W-1:0] m_arr [NS];
    int              m_n    = 0;
    int              m_ncap = 0;
    logic [BLK_W-1:0] exp_q[$];
    logic [BLK_W-1:0] last_xfer = '0;
    int              n_xfer = 0;

    function automatic logic [BLK_W-1:0] rep_blk(input logic [AD_W-1:0] s);
        logic [BLK_W-1:0] r;
        r = '0;
        for (int i = 0; i < AD_W; i++)
            for (int j = 0; j < NS; j++)
                r[i*NS + j] = s[i];
        return r;
    endfunction

    task automatic check_m(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
        m_chk++;
        if (act === exp) m_pass++;
        else $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    endtask

    task automatic check_d(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
        d_chk++;
        if (act === exp) d_pass++;
        else $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    endtask

    // One clock of the behavioural model. It uses input values as they stand at the edge.
    task automatic model_step();
        int               c;
        bit               r;
        bit               done;
        logic [BLK_W-1:0] nb;
        c    = m_cnt;
        r    = m_run;
        done = 0;
        nb   = '0;
        if (m_pend) begin
            m_pend = 0;
            m_led  = (m_s > thresh);
            if (!m_mode) begin
                done = 1;
                nb   = rep_blk(m_s);
            end else begin
                m_arr[m_n] = m_s;
                m_n++;
                if (m_n == NS) begin
                    for (int k = 0; k < NS; k++) nb[k*AD_W +: AD_W] = m_arr[k];
                    m_n  = 0;
                    done = 1;
                end
            end
        end
        if (done) begin
            if (!m_valid || blk_ready) begin
                m_valid = 1;
                exp_q.push_back(nb);
            end else begin
                m_over = 1;
            end
        end else if (m_valid && blk_ready) begin
            m_valid = 0;
        end
        m_en = r && locked && (c == DIV - 2);
        if (r && locked && (c == DIV - 1)) begin
            m_s    = ad_data;
            m_pend = 1;
            m_ncap++;
            if (m_n == 0) m_mode = mode;
        end
        if (locked) m_cnt = (c + 1) % DIV;
        if (!r && start && locked) m_run = 1;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_cnt = 0; m_run = 0; m_en = 0; m_pend = 0; m_mode = 0;
                m_valid = 0; m_over = 0; m_led = 0; m_s = '0; m_n = 0;
                exp_q.delete();
            end else begin
                model_step();
            end
        end
    end

    // Monitor: compare outputs against the model every negedge, and score each transfer.
    initial begin
        forever begin
            @(negedge clk);
            check_m("adc_en_n",  BLK_W'(adc_en_n),  BLK_W'(m_en));
            check_m("led_open",  BLK_W'(led_open),  BLK_W'(m_led));
            check_m("overrun",   BLK_W'(overrun),   BLK_W'(m_over));
            check_m("blk_valid", BLK_W'(blk_valid), BLK_W'(m_valid));
            if (blk_valid && blk_ready) begin
                if (exp_q.size() == 0) begin
                    m_chk++;
                    $display("FAIL unexpected_block @%0t: got %0h, expected no block", $time, blk_data);
                end else begin
                    check_m("blk_data", blk_data, exp_q.pop_front());
                end
                last_xfer = blk_data;
                n_xfer++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_cap(input string name);
        int c0;
        int k;
        c0 = m_ncap;
        k  = 0;
        while (m_ncap == c0 && k < 200) begin
            tick(1);
            k++;
        end
        if (m_ncap == c0) begin
            d_chk++;
            $display("FAIL %s: capture timeout after %0d cycles, required one capture", name, k);
        end
    endtask

    task automatic wait_xfer(input int x0, input string name);
        int k;
        k = 0;
        while (n_xfer == x0 && k < 400) begin
            tick(1);
            k++;
        end
        if (n_xfer == x0) begin
            d_chk++;
            $display("FAIL %s: transfer timeout after %0d cycles, required one transfer", name, k);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    initial begin
        int x0;
        int en_hits;

        tick(3);
        check_d("reset_blk_data",  blk_data,            '0);
        check_d("reset_blk_valid", BLK_W'(blk_valid),   '0);
        check_d("reset_adc_en_n",  BLK_W'(adc_en_n),    '0);
        check_d("reset_led_open",  BLK_W'(led_open),    '0);
        check_d("reset_overrun",   BLK_W'(overrun),     '0);
        rst = 1'b0;
        tick(1);

        // REPLICATE with a constant sample
        mode    = MODE_REPLICATE;
        ad_data = 8'hA5;
        x0      = n_xfer;
        pulse_start();
        wait_xfer(x0, "rep_a5");
        check_d("rep_a5_block", last_xfer, REP_A5);
        en_hits = 0;
        repeat (64) begin
            tick(1);
            en_hits += int'(adc_en_n);
        end
        check_d("en_strobes_per_64", BLK_W'(en_hits), BLK_W'(8));

        // threshold is strict greater-than
        ad_data = 8'h0F;
        wait_cap("led_0f");
        tick(2);
        check_d("led_at_0f", BLK_W'(led_open), '0);
        ad_data = 8'h10;
        wait_cap("led_10");
        tick(2);
        check_d("led_at_10", BLK_W'(led_open), BLK_W'(1'b1));

        // PACK with ramp 00..0F
        do_reset();
        mode = MODE_PACK;
        x0   = n_xfer;
        pulse_start();
        for (int k = 0; k < NS; k++) begin
            ad_data = AD_W'(k);
            wait_cap("pack_cap");
        end
        wait_xfer(x0, "pack_block");
        check_d("pack_block", last_xfer, PACK_SEQ);

        // PACK with lock lost for 20 cycles after the fifth capture
        do_reset();
        mode = MODE_PACK;
        x0   = n_xfer;
        pulse_start();
        for (int k = 0; k < NS; k++) begin
            ad_data = AD_W'(k);
            wait_cap("unlock_cap");
            if (k == 4) begin
                locked  = 1'b0;
                en_hits = 0;
                repeat (20) begin
                    tick(1);
                    en_hits += int'(adc_en_n);
                end
                locked = 1'b1;
                check_d("no_en_while_unlocked", BLK_W'(en_hits), '0);
            end
        end
        wait_xfer(x0, "unlock_block");
        check_d("unlock_block", last_xfer, PACK_SEQ);

        // Reset after seven PACK captures
        do_reset();
        mode = MODE_PACK;
        pulse_start();
        for (int k = 0; k < 7; k++) begin
            ad_data = AD_W'(8'h80 + k);
            wait_cap("pre_reset_cap");
        end
        tick(1);
        rst = 1'b1;
        #1;
        check_d("async_rst_led_open",  BLK_W'(led_open),  '0);
        check_d("async_rst_blk_valid", BLK_W'(blk_valid), '0);
        check_d("async_rst_blk_data",  blk_data,          '0);
        check_d("async_rst_adc_en_n",  BLK_W'(adc_en_n),  '0);
        tick(2);
        rst = 1'b0;
        x0  = n_xfer;
        pulse_start();
        for (int k = 0; k < NS; k++) begin
            ad_data = AD_W'(8'h40 + k);
            wait_cap("post_reset_cap");
        end
        wait_xfer(x0, "post_reset_block");
        check_d("post_reset_block", last_xfer, PACK_40);

        // Overrun: two REPLICATE blocks complete while downstream stalls
        do_reset();
        mode      = MODE_REPLICATE;
        blk_ready = 1'b0;
        ad_data   = 8'hA5;
        pulse_start();
        wait_cap("ovr_cap1");
        ad_data = 8'h3C;
        wait_cap("ovr_cap2");
        tick(2);
        check_d("overrun_set",      BLK_W'(overrun),   BLK_W'(1'b1));
        check_d("overrun_valid",    BLK_W'(blk_valid), BLK_W'(1'b1));
        check_d("overrun_data_held", blk_data,         REP_A5);
        x0        = n_xfer;
        blk_ready = 1'b1;
        wait_xfer(x0, "overrun_xfer");
        check_d("overrun_first_block", last_xfer, REP_A5);

        // Randomized soak
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            locked    = ($urandom_range(0, 9) != 0);
            start     = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0) mode = ~mode;
            thresh    = AD_W'($urandom);
            ad_data   = AD_W'($urandom);
            blk_ready = ($urandom_range(0, 3) != 0);
            if (i == 2000) rst = 1'b1;
            if (i == 2003) rst = 1'b0;
            tick(1);
        end
        locked    = 1'b1;
        blk_ready = 1'b1;
        start     = 1'b0;
        tick(20);
        check_d("queue_drained", BLK_W'(exp_q.size()), BLK_W'(blk_valid));

        $display("%0d/%0d checks passed", m_pass + d_pass, m_chk + d_chk);
        $finish;
    end

endmodule

// File: doc/adc_block_builder.md
ADC_BLOCK_BUILDER -- requirements
Module: adc_block_builder

Interface
REQ-001 Parameter AD_W, default 8, ADC sample width in bits.
REQ-002 Parameter BLK_W, default 128, output block width; SHALL be an integer multiple of AD_W (NS = BLK_W/AD_W, default 16).
REQ-003 Parameter DIV, default 8, sample period in clocks; legal range 2..256.
REQ-004 ADC_CLK_90  in  1  sole clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, asynchronous assert, active-high.
REQ-006 locked  in  1  clock-source lock; low freezes all counters.
REQ-007 start  in  1  arm request; sampled only while locked=1.
REQ-008 mode  in  1  0 = REPLICATE, 1 = PACK.
REQ-009 thresh  in  AD_W  threshold for led_open.
REQ-010 ad_data  in  AD_W  ADC output bus.
REQ-011 ADC_EN_N  out  1  one-cycle conversion strobe to ADC.
REQ-012 blk_data  out  BLK_W  assembled block.
REQ-013 blk_valid  out  1  block available.
REQ-014 blk_ready  in  1  downstream accepts block.
REQ-015 led_open  out  1  last sample > thresh.
REQ-016 overrun  out  1  sticky flag: a completed block was dropped.

Function
REQ-017 FSM states IDLE, RUN; IDLE->RUN when start=1 and locked=1; RUN is left only by reset.
REQ-018 Divider cnt counts 0..DIV-1 and wraps, advancing only while locked=1, in either state.
REQ-019 ADC_EN_N SHALL be 1 for exactly the cycle after the edge where cnt==DIV-2 in RUN, else 0.
REQ-020 Capture strobe: at the edge where cnt==DIV-1 in RUN, ad_q <= ad_data.
REQ-021 led_open SHALL update one edge after each capture: 1 iff ad_q > thresh (unsigned, strict).
REQ-022 REPLICATE: every capture completes a block; bit i of ad_q fills blk_data[(i+1)*NS-1 : i*NS] with all-ones or all-zeros.
REQ-023 PACK: slot counter 0..NS-1; capture k writes ad_q to blk_data bits [(k+1)*AD_W-1 : k*AD_W] (first sample in LSBs); capture at slot NS-1 completes the block, slot wraps to 0.
REQ-024 mode SHALL be latched when slot==0 at a capture; changes mid-block take effect on the next block.
REQ-025 Completion latency: blk_valid rises on the edge one cycle after the capture edge that completes the block.
REQ-026 Handshake: transfer when blk_valid=1 and blk_ready=1; blk_valid stays 1 and blk_data stable until transfer; blk_valid falls the edge after transfer unless a new block completes on that edge.
REQ-027 Completion while blk_valid=1 and blk_ready=0: new block dropped, blk_data unchanged, overrun set to 1 until reset.
REQ-028 Completion in the same cycle as a transfer: new block loads, blk_valid stays 1, no overrun.
REQ-029 PACK assembly SHALL use a separate shadow register so blk_data never changes while blk_valid=1.
REQ-030 locked falling mid-block: cnt, slot and partial block hold; resume on relock without loss.

Reset
REQ-031 rst=1 forces IDLE, cnt=0, slot=0, ad_q=0, shadow=0, ADC_EN_N=0, blk_data=0, blk_valid=0, led_open=0, overrun=0, latched mode=REPLICATE.
REQ-032 Reset mid-block discards the partial block; no block is emitted for it after release.

Structure
REQ-033 Package adc_blk_pkg holds mode encodings (MODE_REPLICATE=0, MODE_PACK=1), FSM state type and parameter defaults.
REQ-034 Sub-module adc_sample_timer contains divider, ADC_EN_N generation and capture strobe.

Verification
REQ-035 DIV=8, REPLICATE, start pulse, ad_data=8'hA5 -> ADC_EN_N high 1 cycle every 8; blk_data=128'hFFFF_0000_FFFF_0000_0000_FFFF_0000_FFFF, blk_valid 1 cycle after capture.
REQ-036 PACK, ad_data 8'h00..8'h0F over 16 captures, blk_ready=1 -> one block 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100.
REQ-037 REPLICATE, blk_ready=0 across two captures -> first block held, overrun=1, blk_data unchanged.
REQ-038 thresh=8'h0F, samples 8'h0F then 8'h10 -> led_open 0 then 1.
REQ-039 PACK, locked dropped for 20 cycles after capture 5 -> no ADC_EN_N during drop; block after relock equals uninterrupted result.
REQ-040 rst asserted after capture 7 in PACK -> all outputs 0 immediately; next block contains only post-reset samples.
